wordcopy_sched: RTL and testbench
=================================

Name: wordcopy_sched

Overview:
Descriptor-queue scheduler that sequences the wordcopy accelerator through its 4-bit Avalon-MM slave port. The host pushes copy descriptors (dst, src, word count) into a small FIFO. The block programs wordcopy's registers for each descriptor, starts it, and stalls on the completion read. It then retires the job and moves to the next. It sits between the host interconnect and wordcopy's slave port; wordcopy's SDRAM master port is untouched.

Parameters:
DEPTH, 4, descriptor FIFO entries (power of two, 2..16)
AW, 32, width of each dst/src/count field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
slave_waitrequest  out  1  host port stall; tied 0 (single-cycle accesses)
slave_address  in  3  host register select
slave_read  in  1  host read strobe
slave_readdata  out  32  host read data, combinational from registers
slave_write  in  1  host write strobe
slave_writedata  in  32  host write data
copy_waitrequest  in  1  wordcopy slave stall
copy_address  out  4  wordcopy register select (0 start/done, 1 dst, 2 src, 3 count)
copy_read  out  1  read strobe to wordcopy
copy_readdata  in  32  wordcopy read data (ignored; the read is used for its stall)
copy_write  out  1  write strobe to wordcopy
copy_writedata  out  32  write data to wordcopy

Behaviour:
- Host map:
  - 0 DST (RW)
  - 1 SRC (RW)
  - 2 CNT (RW)
  - 3 PUSH: any write enqueues {DST, SRC, CNT}. Reads return 0.
  - 4 STATUS (RO): [4:0] fifo level, [8] busy, [9] overflow sticky, [10] irq pending
  - 5 DONE: 32-bit retired-job count, wraps at 2^32. Any write to 5 clears it.
  - 6 CTRL: write bit0=1 clears overflow; bit1=1 clears irq pending.
  - Addresses 7: reads return 0, writes are ignored.
- Reset values:
  - All copy_* strobes are 0; copy_address and copy_writedata are 0.
  - Staging registers are 0, the FIFO is empty, DONE is 0, flags are 0, state is IDLE.
- FIFO behaviour:
  - A push when the level equals DEPTH drops the descriptor and sets overflow. The level is unchanged.
  - A push and a pop in the same cycle both take effect; the level is unchanged.
  - A push while the FIFO is full and a pop occurs in the same cycle is accepted.
- FSM states: IDLE, WR_DST, WR_SRC, WR_CNT, WR_START, WAIT_DONE, RETIRE.
  - IDLE: if the FIFO is non-empty, pop into the active-descriptor register next cycle.
    - If its count is 0, go to RETIRE.
    - Otherwise go to WR_DST.
  - WR_DST / WR_SRC / WR_CNT / WR_START drive copy_write=1, with copy_address 1 / 2 / 3 / 0 respectively. copy_writedata is dst / src / count / 1.
  - Every strobe, address and data value is held stable while copy_waitrequest=1. The state advances in the first cycle copy_waitrequest=0.
  - WAIT_DONE: copy_read=1, copy_address=0, held until copy_waitrequest=0. Wordcopy stalls this read until the copy finishes.
  - RETIRE: one cycle. DONE increments. Go to IDLE.
- busy = (state != IDLE) or fifo level != 0.
- Minimum latency with no stalls: pop to RETIRE is 6 cycles. Back-to-back descriptors incur one IDLE cycle between them.
- Staging registers may be rewritten while a job is running; the running job uses its latched copy.
- Reset asserted mid-job: all state is abandoned immediately. Wordcopy shares the same reset.

Optional Feature:
WORDCOPY_SCHED_IRQ_EN:
- Defined: adds output port irq (1 bit).
- irq pending is set in the RETIRE cycle when the FIFO is empty and no push occurs that cycle (queue drained).
- irq mirrors irq pending and is cleared by CTRL bit1. Set takes priority over a clear in the same cycle.
- Not defined: no irq port; STATUS[10] reads 0; CTRL bit1 is ignored.

Decomposition:
- Package wordcopy_sched_pkg holds:
  - host register address constants (REG_DST..REG_CTRL)
  - wordcopy register offsets (WC_START=0, WC_DST=1, WC_SRC=2, WC_CNT=3)
  - packed struct desc_t {dst, src, cnt}
  - state enum sched_state_e
- One sub-module: sched_desc_fifo. It is a synchronous FIFO of desc_t with push, pop, full, empty and level outputs, parameterised by DEPTH.

Test Plan:
- Single job: DST=0x1000_0000, SRC=0x2000_0000, CNT=4, then PUSH, with copy_waitrequest=0 except 20 cycles high during WAIT_DONE.
  - Required: writes (1,0x1000_0000), (2,0x2000_0000), (3,4), (0,1) in order, then a read at address 0.
  - After the stall, DONE=1 and busy=0.
- Waitrequest hold: assert copy_waitrequest for 3 cycles during WR_SRC.
  - Required: address 2, data 0x2000_0000 and the write strobe stay stable for all 4 cycles; exactly one write is accepted.
- Overflow: push 5 descriptors with wordcopy stalled in WAIT_DONE (DEPTH=4).
  - Required: level reads 3 plus 1 active job; the 5th push after the queue is full sets STATUS[9].
  - CTRL=1 clears STATUS[9].
- Zero count: push CNT=0.
  - Required: no copy_write or copy_read activity; DONE increments within 3 cycles.
- Reset mid-job: assert rst during WR_CNT.
  - Required: all copy_* outputs are 0 in the same cycle; level=0 and DONE=0 after release.
- IRQ (macro defined): run 2 queued jobs.
  - Required: irq rises only after the second RETIRE.
  - CTRL=2 drops irq on the next cycle.

Source files
------------

// File: rtl/wordcopy_sched_pkg.sv
// wordcopy_sched_pkg: shared types and constants for the wordcopy descriptor scheduler.
//   - host register map (REG_*), wordcopy slave register offsets (WC_*)
//   - desc_t: one queued copy job {dst, src, cnt}
//   - sched_state_e: sequencing FSM states
package wordcopy_sched_pkg;

    localparam int unsigned DESC_AW = 32;

    // Host-side register map
    localparam logic [2:0] REG_DST    = 3'd0;
    localparam logic [2:0] REG_SRC    = 3'd1;
    localparam logic [2:0] REG_CNT    = 3'd2;
    localparam logic [2:0] REG_PUSH   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_DONE   = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;

    // wordcopy slave register offsets
    localparam logic [3:0] WC_START = 4'd0;
    localparam logic [3:0] WC_DST   = 4'd1;
    localparam logic [3:0] WC_SRC   = 4'd2;
    localparam logic [3:0] WC_CNT   = 4'd3;

    typedef struct packed {
        logic [DESC_AW-1:0] dst;
        logic [DESC_AW-1:0] src;
        logic [DESC_AW-1:0] cnt;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_DST,
        WR_SRC,
        WR_CNT,
        WR_START,
        WAIT_DONE,
        RETIRE
    } sched_state_e;

endpackage

// File: rtl/sched_desc_fifo.sv
// sched_desc_fifo: synchronous FIFO of copy descriptors.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   enqueue request and descriptor (ignored when full unless popping)
//   pop, pop_data     dequeue request (ignored when empty); pop_data is the current head
//   full, empty       occupancy flags
//   level             number of stored entries (0..DEPTH)
module sched_desc_fifo
    import wordcopy_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  desc_t      push_data,
    input  logic       pop,
    output desc_t      pop_data,
    output logic       full,
    output logic       empty,
    output logic [4:0] level
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    desc_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [4:0]     count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full     = (count_q == 5'(DEPTH));
    assign empty    = (count_q == 5'd0);
    assign level    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 5'd1;
            else if (pop_ok && !push_ok) count_q <= count_q - 5'd1;
        end
    end

endmodule

// File: rtl/wordcopy_sched.sv
// wordcopy_sched: queues copy descriptors from the host and sequences the wordcopy
// accelerator through its slave port (dst, src, count, start, then a stalling done read).
// Optional feature macro: WORDCOPY_SCHED_IRQ_EN adds the irq output (queue-drained interrupt).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   slave_*                  host register port (single-cycle, waitrequest tied 0)
//   copy_*                   master side towards wordcopy's slave port
//   irq                      (WORDCOPY_SCHED_IRQ_EN only) irq pending flag
module wordcopy_sched
    import wordcopy_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = DESC_AW
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        copy_waitrequest,
    output logic [3:0]  copy_address,
    output logic        copy_read,
    input  logic [31:0] copy_readdata,
    output logic        copy_write,
    output logic [31:0] copy_writedata
`ifdef WORDCOPY_SCHED_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [AW-1:0] dst_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] cnt_q;
    desc_t         active_q;
    sched_state_e  state_q;
    logic [31:0]   done_q;
    logic          ovf_q;
    logic          irq_pend;

    desc_t         push_desc;
    desc_t         head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [4:0]    fifo_level;
    logic          busy;
    logic          wr_ctrl;
    logic          unused_inputs;

    // Read strobe has no side effects and wordcopy's read data is irrelevant: the done
    // read exists only for its stall.
    assign unused_inputs = ^{slave_read, copy_readdata};

    assign slave_waitrequest = 1'b0;

    assign push    = slave_write && (slave_address == REG_PUSH);
    assign wr_ctrl = slave_write && (slave_address == REG_CTRL);
    assign pop     = (state_q == IDLE) && !fifo_empty;
    assign busy    = (state_q != IDLE) || !fifo_empty;

    assign push_desc = '{dst: dst_q, src: src_q, cnt: cnt_q};

    sched_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_desc),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Staging registers, retired-job counter and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q  <= '0;
            src_q  <= '0;
            cnt_q  <= '0;
            done_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (slave_write && slave_address == REG_DST) dst_q <= slave_writedata[AW-1:0];
            if (slave_write && slave_address == REG_SRC) src_q <= slave_writedata[AW-1:0];
            if (slave_write && slave_address == REG_CNT) cnt_q <= slave_writedata[AW-1:0];

            if (slave_write && slave_address == REG_DONE) done_q <= '0;
            else if (state_q == RETIRE)                   done_q <= done_q + 32'd1;

            if (push && fifo_full && !pop)          ovf_q <= 1'b1;
            else if (wr_ctrl && slave_writedata[0]) ovf_q <= 1'b0;
        end
    end

`ifdef WORDCOPY_SCHED_IRQ_EN
    logic irq_q;

    // Queue drained: last job retires with nothing left and nothing arriving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (state_q == RETIRE && fifo_empty && !push) begin
            irq_q <= 1'b1;
        end else if (wr_ctrl && slave_writedata[1]) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_pend = irq_q;
    assign irq      = irq_q;
`else
    assign irq_pend = 1'b0;
`endif

    // Sequencer with registered copy_* outputs. Each bus state holds its outputs until
    // the cycle wordcopy drops waitrequest, then loads the next state's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            active_q       <= '0;
            copy_write     <= 1'b0;
            copy_read      <= 1'b0;
            copy_address   <= '0;
            copy_writedata <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        active_q <= head;
                        if (head.cnt == '0) begin
                            state_q <= RETIRE;
                        end else begin
                            state_q        <= WR_DST;
                            copy_write     <= 1'b1;
                            copy_address   <= WC_DST;
                            copy_writedata <= head.dst;
                        end
                    end
                end
                WR_DST: begin
                    if (!copy_waitrequest) begin
                        state_q        <= WR_SRC;
                        copy_address   <= WC_SRC;
                        copy_writedata <= active_q.src;
                    end
                end
                WR_SRC: begin
                    if (!copy_waitrequest) begin
                        state_q        <= WR_CNT;
                        copy_address   <= WC_CNT;
                        copy_writedata <= active_q.cnt;
                    end
                end
                WR_CNT: begin
                    if (!copy_waitrequest) begin
                        state_q        <= WR_START;
                        copy_address   <= WC_START;
                        copy_writedata <= 32'd1;
                    end
                end
                WR_START: begin
                    if (!copy_waitrequest) begin
                        state_q        <= WAIT_DONE;
                        copy_write     <= 1'b0;
                        copy_read      <= 1'b1;
                        copy_address   <= WC_START;
                        copy_writedata <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (!copy_waitrequest) begin
                        state_q   <= RETIRE;
                        copy_read <= 1'b0;
                    end
                end
                RETIRE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            REG_DST:    slave_readdata = 32'(dst_q);
            REG_SRC:    slave_readdata = 32'(src_q);
            REG_CNT:    slave_readdata = 32'(cnt_q);
            REG_STATUS: slave_readdata = {21'd0, irq_pend, ovf_q, busy, 3'd0, fifo_level};
            REG_DONE:   slave_readdata = done_q;
            default:    slave_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wordcopy_sched.sv
// tb_wordcopy_sched: directed, self-checking bench for wordcopy_sched (DEPTH=4).
// Register access vectors are table-driven; job sequencing, stalls, overflow, zero count,
// irq (when WORDCOPY_SCHED_IRQ_EN is defined) and mid-job reset are hand-written sequences.
module tb_wordcopy_sched;
    import wordcopy_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        slave_waitrequest;
    logic [2:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        copy_waitrequest = 1'b0;
    logic [3:0]  copy_address;
    logic        copy_read;
    logic [31:0] copy_readdata = '0;
    logic        copy_write;
    logic [31:0] copy_writedata;
`ifdef WORDCOPY_SCHED_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    wordcopy_sched #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .slave_waitrequest (slave_waitrequest),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .copy_waitrequest  (copy_waitrequest),
        .copy_address      (copy_address),
        .copy_read         (copy_read),
        .copy_readdata     (copy_readdata),
        .copy_write        (copy_write),
        .copy_writedata    (copy_writedata)
`ifdef WORDCOPY_SCHED_IRQ_EN
        ,
        .irq               (irq)
`endif
    );

    // Accepted wordcopy transfers, logged on the clock edge.
    logic [3:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          rd_cnt = 0;
    int          strobe_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (copy_write && !copy_waitrequest) begin
                log_addr.push_back(copy_address);
                log_data.push_back(copy_writedata);
            end
            if (copy_read && !copy_waitrequest) rd_cnt = rd_cnt + 1;
            if (copy_write || copy_read) strobe_cnt = strobe_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    // Combinational read sampled immediately; callers are already away from the edge.
    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        #1;
        d          = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic wait_write(input logic [3:0] a, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (copy_write && copy_address == a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_read(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (copy_read) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    initial begin
        reg_vec_t    vecs [10];
        logic [31:0] rd;
        logic        ok;
        logic        stable;
        logic        early;
        int          base;
        int          rd0;
        int          s0;
        int          n2;
        logic [3:0]  exp_a [4];
        logic [31:0] exp_d [4];

        vecs[0] = '{1'b0, REG_STATUS, 32'h0, 32'h0, "reset_status"};
        vecs[1] = '{1'b0, REG_DONE,   32'h0, 32'h0, "reset_done"};
        vecs[2] = '{1'b0, REG_DST,    32'h0, 32'h0, "reset_dst"};
        vecs[3] = '{1'b1, REG_DST,    32'h1000_0000, 32'h1000_0000, "dst_rw"};
        vecs[4] = '{1'b1, REG_SRC,    32'h2000_0000, 32'h2000_0000, "src_rw"};
        vecs[5] = '{1'b1, REG_CNT,    32'h0000_0004, 32'h0000_0004, "cnt_rw"};
        vecs[6] = '{1'b1, 3'd7,       32'hFFFF_FFFF, 32'h0, "addr7_ignored"};
        vecs[7] = '{1'b0, REG_PUSH,   32'h0, 32'h0, "push_reads_0"};
        vecs[8] = '{1'b0, REG_STATUS, 32'h0, 32'h0, "status_idle"};
        vecs[9] = '{1'b0, REG_DST,    32'h0, 32'h1000_0000, "dst_kept"};

        exp_a = '{WC_DST, WC_SRC, WC_CNT, WC_START};
        exp_d = '{32'h1000_0000, 32'h2000_0000, 32'd4, 32'd1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {slave_waitrequest, copy_write, copy_read, copy_address},
              32'h0);
        check("reset_writedata", copy_writedata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].wdata);
            host_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // Single job with a 20-cycle stall on the done read
        base = log_addr.size();
        rd0  = rd_cnt;
        host_write(REG_PUSH, 32'h0);
        wait_read(ok);
        check("single_reach_wait_done", 32'(ok), 32'd1);
        copy_waitrequest = 1'b1;
        repeat (20) @(negedge clk);
        check("single_read_held", {copy_read, copy_address}, {1'b1, WC_START});
        copy_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check("single_write_count", 32'(log_addr.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("single_wr%0d_addr", i), 32'(log_addr[base + i]), 32'(exp_a[i]));
            check($sformatf("single_wr%0d_data", i), log_data[base + i], exp_d[i]);
        end
        check("single_read_count", 32'(rd_cnt - rd0), 32'd1);
        host_read(REG_DONE, rd);
        check("single_done", rd, 32'd1);
        host_read(REG_STATUS, rd);
        check("single_busy", 32'(rd[8]), 32'd0);

        // Waitrequest held three cycles during WR_SRC
        base = log_addr.size();
        host_write(REG_PUSH, 32'h0);
        wait_write(WC_SRC, ok);
        check("hold_reach_wr_src", 32'(ok), 32'd1);
        stable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            stable &= copy_write && !copy_read && copy_address == WC_SRC &&
                      copy_writedata == 32'h2000_0000;
            copy_waitrequest = (k < 3);
        end
        check("hold_stable", 32'(stable), 32'd1);
        repeat (10) @(negedge clk);
        n2 = 0;
        for (int i = base; i < log_addr.size(); i++) if (log_addr[i] == WC_SRC) n2++;
        check("hold_one_src_write", 32'(n2), 32'd1);
        check("hold_write_count", 32'(log_addr.size() - base), 32'd4);
        host_read(REG_DONE, rd);
        check("hold_done", rd, 32'd2);

        // Overflow: active job stalled in WAIT_DONE, then fill the queue
        host_write(REG_PUSH, 32'h0);
        wait_read(ok);
        check("ovf_reach_wait_done", 32'(ok), 32'd1);
        copy_waitrequest = 1'b1;
        repeat (3) host_write(REG_PUSH, 32'h0);
        host_read(REG_STATUS, rd);
        check("ovf_level3", rd, 32'h0000_0103);
        host_write(REG_PUSH, 32'h0);
        host_read(REG_STATUS, rd);
        check("ovf_full_no_flag", rd, 32'h0000_0104);
        host_write(REG_PUSH, 32'h0);
        host_read(REG_STATUS, rd);
        check("ovf_flag_set", rd, 32'h0000_0304);
        host_write(REG_CTRL, 32'h1);
        host_read(REG_STATUS, rd);
        check("ovf_flag_cleared", rd, 32'h0000_0104);
        copy_waitrequest = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            host_read(REG_STATUS, rd);
            if (!rd[8]) begin
                ok = 1'b1;
                break;
            end
        end
        check("ovf_drained", 32'(ok), 32'd1);
        host_read(REG_DONE, rd);
        check("ovf_done", rd, 32'd7);
`ifndef WORDCOPY_SCHED_IRQ_EN
        host_read(REG_STATUS, rd);
        check("no_irq_status_bit", 32'(rd[10]), 32'd0);
`endif

        // Zero count: retires without bus activity
        host_write(REG_CNT, 32'h0);
        s0 = strobe_cnt;
        host_write(REG_PUSH, 32'h0);
        repeat (2) @(negedge clk);
        host_read(REG_DONE, rd);
        check("zero_done_3cyc", rd, 32'd8);
        repeat (4) @(negedge clk);
        check("zero_no_strobes", 32'(strobe_cnt - s0), 32'd0);
        host_write(REG_CNT, 32'd4);

`ifdef WORDCOPY_SCHED_IRQ_EN
        // irq only after the second of two queued jobs retires
        host_write(REG_CTRL, 32'h2);
        check("irq_cleared_start", 32'(irq), 32'd0);
        host_write(REG_PUSH, 32'h0);
        host_write(REG_PUSH, 32'h0);
        ok    = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            host_read(REG_DONE, rd);
            if (rd >= 32'd10) begin
                ok = 1'b1;
                break;
            end
            if (irq) early = 1'b1;
            @(negedge clk);
        end
        check("irq_jobs_done", 32'(ok), 32'd1);
        check("irq_not_early", 32'(early), 32'd0);
        check("irq_set", 32'(irq), 32'd1);
        host_read(REG_STATUS, rd);
        check("irq_status_bit", 32'(rd[10]), 32'd1);
        host_write(REG_CTRL, 32'h2);
        check("irq_ctrl_clear", 32'(irq), 32'd0);
`endif

        // Reset in WR_CNT
        host_write(REG_PUSH, 32'h0);
        wait_write(WC_CNT, ok);
        check("rst_reach_wr_cnt", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_copy_ctl", {copy_write, copy_read, copy_address}, 32'h0);
        check("rst_copy_data", copy_writedata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        host_read(REG_STATUS, rd);
        check("rst_status", rd, 32'h0);
        host_read(REG_DONE, rd);
        check("rst_done", rd, 32'h0);
`ifdef WORDCOPY_SCHED_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
